// File: rtl/register_file.sv
// Architectural register file: X0-X30 storage, X31 reads as zero (XZR), two
// combinational read ports with optional write-through, a debug port and a write counter.
module register_file #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32,
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic [4:0]        RA,
  input  logic [4:0]        RB,
  input  logic [4:0]        RW,
  input  logic              RegWr,
  input  logic [DATA_W-1:0] BusW,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic [4:0]        DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WrCount
);

  localparam int         NREGS = 31;
  localparam logic [4:0] XZR   = 5'd31;

  logic [DATA_W-1:0] regs [0:NREGS-1];
  logic [CNT_W-1:0]  wrCount;
  logic [DATA_W-1:0] storedA;
  logic [DATA_W-1:0] storedB;
  logic [DATA_W-1:0] storedDbg;
  logic              wrActive;
  logic              bypassA;
  logic              bypassB;

  // Gating with ResetL keeps every read port at zero while reset is held.
  assign wrActive = ResetL && RegWr && (RW != XZR);

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wrCount <= '0;
    end else if (wrActive) begin
      regs[RW] <= BusW;
      if (wrCount != {CNT_W{1'b1}}) begin
        wrCount <= wrCount + CNT_W'(1);
      end
    end
  end

  // Address 31 matches no entry, so it falls through to the zero default.
  always_comb begin
    storedA   = '0;
    storedB   = '0;
    storedDbg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RA == 5'(i)) storedA = regs[i];
      if (RB == 5'(i)) storedB = regs[i];
      if (DbgAddr == 5'(i)) storedDbg = regs[i];
    end
  end

  assign bypassA = (BYPASS != 0) && wrActive && (RA == RW);
  assign bypassB = (BYPASS != 0) && wrActive && (RB == RW);

  assign BusA    = bypassA ? BusW : storedA;
  assign BusB    = bypassB ? BusW : storedB;
  assign DbgData = storedDbg;
  assign WrCount = wrCount;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected values, a monitor on the
// falling clock edge pops and compares them against three differently parameterised copies.
module tb_register_file;

  logic        Clk;
  logic        ResetL;
  logic [4:0]  RA, RB, RW, DbgAddr;
  logic        RegWr;
  logic [63:0] BusW;

  logic [63:0] busA0, busB0, dbg0;
  logic [31:0] wrCount0;
  logic [63:0] busA1, busB1, dbg1;
  logic [31:0] wrCount1;
  logic [63:0] busA2, busB2, dbg2;
  logic [3:0]  wrCount2;

  register_file #(.BYPASS(1), .CNT_W(32)) u0 (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RW(RW), .RegWr(RegWr), .BusW(BusW),
    .BusA(busA0), .BusB(busB0), .DbgAddr(DbgAddr), .DbgData(dbg0), .WrCount(wrCount0));

  register_file #(.BYPASS(0), .CNT_W(32)) u1 (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RW(RW), .RegWr(RegWr), .BusW(BusW),
    .BusA(busA1), .BusB(busB1), .DbgAddr(DbgAddr), .DbgData(dbg1), .WrCount(wrCount1));

  register_file #(.BYPASS(1), .CNT_W(4)) u2 (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RW(RW), .RegWr(RegWr), .BusW(BusW),
    .BusA(busA2), .BusB(busB2), .DbgAddr(DbgAddr), .DbgData(dbg2), .WrCount(wrCount2));

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam int A0 = 0, B0 = 1, D0 = 2, C0 = 3, A1 = 4, B1 = 5, D1 = 6, C2 = 7, D2 = 8;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      A0: return busA0;
      B0: return busB0;
      D0: return dbg0;
      C0: return 64'(wrCount0);
      A1: return busA1;
      B1: return busB1;
      D1: return dbg1;
      C2: return 64'(wrCount2);
      D2: return dbg2;
      default: return 64'hx;
    endcase
  endfunction

  // Monitor: everything queued since the last falling edge is checked at this one.
  initial begin
    chk_t        e;
    logic [63:0] act;
    forever begin
      @(negedge Clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = actual(e.sel);
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input int sel, input logic [63:0] e);
    q.push_back('{nm, sel, e});
  endtask

  task automatic sync();
    @(negedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    RegWr = 1'b1;
    RW    = a;
    BusW  = d;
    @(posedge Clk);
    #1;
    RegWr = 1'b0;
  endtask

  task automatic pulseReset();
    @(posedge Clk);
    #1;
    ResetL = 1'b0;
    #1;
    chk("rst_cnt0", C0, 64'h0);
    chk("rst_cnt2", C2, 64'h0);
    sync();
    ResetL = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ResetL = 1'b0; RegWr = 1'b0; RA = 5'd0; RB = 5'd31; RW = 5'd0;
    BusW = 64'h0; DbgAddr = 5'd30;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_busA_x0", A0, 64'h0);
    chk("reset_busB_x31", B0, 64'h0);
    chk("reset_dbg_x30", D0, 64'h0);
    chk("reset_wrcount", C0, 64'h0);
    sync();
    ResetL = 1'b1;

    // Reset clear with a pending write discarded
    wr(5'd5, 64'hDEAD_BEEF_0000_0001);
    DbgAddr = 5'd5;
    chk("preload_x5", D0, 64'hDEAD_BEEF_0000_0001);
    chk("preload_cnt", C0, 64'h1);
    sync();
    @(posedge Clk);
    #1;
    ResetL = 1'b0; RegWr = 1'b1; RW = 5'd6; BusW = 64'h55; RA = 5'd6;
    #1;
    chk("rstclr_dbg_x5", D0, 64'h0);
    chk("rstclr_cnt", C0, 64'h0);
    chk("rstclr_no_bypass", A0, 64'h0);
    sync();
    ResetL = 1'b1; RegWr = 1'b0;

    // Basic write/read
    wr(5'd3, 64'h1234_5678_9ABC_DEF0);
    RA = 5'd3; RB = 5'd3;
    chk("basic_busA", A0, 64'h1234_5678_9ABC_DEF0);
    chk("basic_busB", B0, 64'h1234_5678_9ABC_DEF0);
    chk("basic_busA_nobyp", A1, 64'h1234_5678_9ABC_DEF0);
    chk("basic_cnt", C0, 64'h1);
    sync();

    // XZR write discarded
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    RA = 5'd31; RB = 5'd5; DbgAddr = 5'd3;
    chk("xzr_busA", A0, 64'h0);
    chk("xzr_busB_x5", B0, 64'h0);
    chk("xzr_cnt", C0, 64'h1);
    chk("xzr_x3_kept", D0, 64'h1234_5678_9ABC_DEF0);
    sync();
    DbgAddr = 5'd31;
    #1;
    chk("xzr_dbg", D0, 64'h0);
    sync();

    // Bypass vs no bypass
    wr(5'd7, 64'h10);
    wr(5'd8, 64'h88);
    RegWr = 1'b1; RW = 5'd7; BusW = 64'h20; RA = 5'd7; RB = 5'd8; DbgAddr = 5'd7;
    #1;
    chk("byp_busA", A0, 64'h20);
    chk("byp_busB_x8", B0, 64'h88);
    chk("byp_dbg_old", D0, 64'h10);
    chk("nobyp_busA_old", A1, 64'h10);
    chk("nobyp_busB_x8", B1, 64'h88);
    chk("nobyp_dbg_old", D1, 64'h10);
    @(posedge Clk);
    #1;
    RegWr = 1'b0;
    chk("byp_busA_after", A0, 64'h20);
    chk("nobyp_busA_after", A1, 64'h20);
    chk("byp_dbg_after", D0, 64'h20);
    chk("byp_cnt", C0, 64'h4);
    sync();

    // Both ports bypass the same write; write withdrawn before the edge
    @(posedge Clk);
    #1;
    RegWr = 1'b1; RW = 5'd7; BusW = 64'h30; RA = 5'd7; RB = 5'd7;
    #1;
    chk("dual_byp_busA", A0, 64'h30);
    chk("dual_byp_busB", B0, 64'h30);
    chk("dual_nobyp_busA", A1, 64'h20);
    chk("dual_nobyp_busB", B1, 64'h20);
    sync();
    RegWr = 1'b0;
    @(posedge Clk);
    #1;
    chk("withdrawn_x7", D0, 64'h20);
    chk("withdrawn_cnt", C0, 64'h4);
    sync();

    // Counter saturation on the 4-bit instance
    pulseReset();
    DbgAddr = 5'd1;
    for (int i = 1; i <= 17; i++) begin
      wr(5'd1, 64'(i));
      if (i == 14) chk("sat_cnt_14", C2, 64'hE);
      if (i == 15) chk("sat_cnt_15", C2, 64'hF);
    end
    chk("sat_cnt_17", C2, 64'hF);
    chk("sat_x1_last", D2, 64'h11);
    chk("wide_cnt_17", C0, 64'h11);
    sync();
    sync();

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file for the 64-bit single-cycle datapath. It holds X0–X30 and treats X31 as a hardwired zero (XZR). It sources the ALU's two operand buses, BusA and BusB, and accepts the writeback value on BusW. It also provides a debug read port and a saturating write counter, which the bench uses to check architectural state without probing internals.

## Interface
Parameters:
- `BYPASS`, default 1. When 1, a same-cycle write to a register being read is forwarded onto the read bus (write-through). When 0, reads return the stored value only.
- `CNT_W`, default 32. Width of the write counter.

Ports:
- `Clk`  input  1  Single clock, rising-edge.
- `ResetL`  input  1  Asynchronous, active-low reset.
- `RA`  input  5  Read address for port A.
- `RB`  input  5  Read address for port B.
- `RW`  input  5  Write address.
- `RegWr`  input  1  Write enable, sampled at rising `Clk`.
- `BusW`  input  64  Write data.
- `BusA`  output  64  Port A read data, feeds the ALU's BusA.
- `BusB`  output  64  Port B read data, feeds the ALU's BusB and the store-data path.
- `DbgAddr`  input  5  Debug read address.
- `DbgData`  output  64  Debug read data. Never bypassed.
- `WrCount`  output  `CNT_W`  Count of committed writes, saturating.

## Operation
- Storage is 31 × 64-bit registers, indices 0–30. Index 31 has no storage.
- Any read of address 31 returns 64'h0. This applies to `BusA`, `BusB` and `DbgData`.
- Reads are combinational from the stored array and the address inputs.
- A write commits on the rising `Clk` when `ResetL`=1, `RegWr`=1 and `RW`≠31: `reg[RW]` ← `BusW`.
- A write with `RW`=31 is discarded. It does not change any register or `WrCount`.
- `WrCount` increments by 1 on each committed write. It saturates at all-ones and never wraps.
- Bypass applies when `BYPASS`=1, `RegWr`=1, `RW`≠31 and `RA`==`RW`: `BusA` = `BusW`. `BusB` follows the same rule using `RB`.
- When `RA`==`RB`==`RW`, both ports bypass.
- With `BYPASS`=0, a same-cycle read of `RW` returns the pre-write value. The new value is visible in the cycle after the edge.
- The bypass is combinational. `BusA`/`BusB` must not be registered.
- No read port may produce X after reset for any address.

## Timing
- Reset is asserted asynchronously on `ResetL`=0, which immediately clears all 31 registers to 0 and `WrCount` to 0.
- While `ResetL`=0, the `BusA`/`BusB`/`DbgData` reset values are 0 for every address. This holds with no bypass, because writes are blocked during reset.
- Reset deassertion is synchronized externally. The first write can commit on the first rising edge with `ResetL`=1.
- Asserting reset mid-cycle discards any pending write. Registers and `WrCount` read 0 before the next edge.
- Write latency is 1 edge: data presented in cycle n is stored at the end of cycle n.
- Read latency is 0 cycles, combinational.
- Bypass latency is 0 cycles, combinational from `BusW`/`RW`/`RegWr`.
- There is exactly one write port, so no write-write conflicts can occur.
- Read-during-write follows the `BYPASS` parameter. `DbgData` always shows the stored value.
- The critical path is an address or `BusW` change, through the read mux and bypass mux, into the ALU. The ALU computes in the same cycle.

## Test plan
- **Reset clear:** preload X5=64'hDEAD_BEEF_0000_0001, then pulse `ResetL`=0 between edges. Required: `DbgAddr`=5 gives 0 immediately, and `WrCount`=0.
- **Basic write/read:** `RegWr`=1, `RW`=3, `BusW`=64'h1234_5678_9ABC_DEF0, one edge, then `RA`=3, `RB`=3. Required: both buses read 64'h1234_5678_9ABC_DEF0, and `WrCount`=1.
- **XZR:** `RegWr`=1, `RW`=31, `BusW`=64'hFFFF_FFFF_FFFF_FFFF, one edge. Required: `RA`=31 reads 0, `WrCount` is unchanged, and no other register changes.
- **Bypass, `BYPASS`=1:** X7=64'h10. In the same cycle, `RegWr`=1, `RW`=7, `BusW`=64'h20, `RA`=7, `RB`=8. Required: `BusA`=64'h20 before the edge, `BusB`=X8, and `DbgData`(7)=64'h10 until the edge.
- **No bypass, `BYPASS`=0:** the same stimulus as the bypass scenario. Required: `BusA`=64'h10 before the edge and 64'h20 after it.
- **Counter saturation, `CNT_W`=4:** 17 writes to X1. Required: `WrCount` reaches 4'hF and stays there, and X1 holds the last written value.
